// File: rtl/mempak_pkg.sv
// Shared types, sizes and the N64 data-CRC byte step for the mempak block-transfer path.
package mempak_pkg;

    localparam int BLOCK_BYTES = 32;
    localparam int HALFWORDS = BLOCK_BYTES / 2;
    localparam logic [7:0] CRC_POLY = 8'h85;
    localparam logic [15:0] MEMPAK_ADDR_LIMIT = 16'h8000;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RD_REQ    = 4'd1,
        RD_WAIT   = 4'd2,
        RD_HI     = 4'd3,
        RD_LO     = 4'd4,
        WR_HI     = 4'd5,
        WR_LO     = 4'd6,
        WR_COMMIT = 4'd7,
        CRC_FIN   = 4'd8,
        DONE      = 4'd9
    } mempak_state_e;

    // Shifts one byte into the CRC, MSB first; feedback taken from the bit shifted out.
    function automatic logic [7:0] crc8_byte_update(input logic [7:0] crc, input logic [7:0] data_byte);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7];
            c  = {c[6:0], data_byte[i]};
            if (fb) begin
                c = c ^ CRC_POLY;
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/mempak_block_xfer_if.sv
// Command, byte-stream, CRC and SPRAM-port signals of the mempak block transfer engine.
interface mempak_block_xfer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic        wr_byte_valid;
    logic        wr_byte_ready;
    logic [7:0]  wr_byte;
    logic        rd_byte_valid;
    logic        rd_byte_ready;
    logic [7:0]  rd_byte;
    logic        crc_valid;
    logic [7:0]  crc_out;
    logic        busy;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_write_data;
    logic [15:0] mem_read_data;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, wr_byte_valid, wr_byte, rd_byte_ready, mem_read_data,
        output cmd_ready, wr_byte_ready, rd_byte_valid, rd_byte, crc_valid, crc_out, busy,
               mem_read_enable, mem_write_enable, mem_address, mem_write_data
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, wr_byte_valid, wr_byte, rd_byte_ready, mem_read_data,
        input  cmd_ready, wr_byte_ready, rd_byte_valid, rd_byte, crc_valid, crc_out, busy,
               mem_read_enable, mem_write_enable, mem_address, mem_write_data
    );

endinterface

// File: rtl/mempak_crc8.sv
// Running N64 data CRC: synchronous clear, one byte folded in per enabled cycle.
module mempak_crc8
    import mempak_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       byte_en,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);

    logic [7:0] crc_r;

    // CRC accumulator; clear wins over a same-cycle byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_r <= 8'h00;
        end else if (clear) begin
            crc_r <= 8'h00;
        end else if (byte_en) begin
            crc_r <= crc8_byte_update(crc_r, byte_in);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc_out = crc_r;

endmodule

// File: rtl/mempak_block_xfer.sv
// Mempak 32-byte block read/write engine: halfword SPRAM accesses, byte streams and data CRC.
module mempak_block_xfer #(
    parameter int BLOCK_BYTES = mempak_pkg::BLOCK_BYTES
) (
    input  logic                clk,
    input  logic                reset,
    mempak_block_xfer_if.slave  bus
);

    import mempak_pkg::*;

    localparam int N_HALF = BLOCK_BYTES / 2;
    localparam int IDX_W = (N_HALF > 1) ? $clog2(N_HALF) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_HALF - 1);

    mempak_state_e    state_r;
    mempak_state_e    state_next_s;
    logic [15:0]      base_r;
    logic [15:0]      base_next_s;
    logic             oor_r;
    logic             oor_next_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_next_s;
    logic [15:0]      hw_buf_r;
    logic [15:0]      hw_buf_next_s;
    logic [15:0]      addr_next_s;
    logic             last_s;
    logic             crc_clear_s;
    logic             crc_en_s;
    logic [7:0]       crc_in_s;
    logic [7:0]       crc_run_s;
    logic             addr_crc_unused_s;

    logic             cmd_ready_r;
    logic             busy_r;
    logic             wr_byte_ready_r;
    logic             rd_byte_valid_r;
    logic [7:0]       rd_byte_r;
    logic             crc_valid_r;
    logic [7:0]       crc_out_r;
    logic             mem_read_enable_r;
    logic             mem_write_enable_r;
    logic [15:0]      mem_address_r;
    logic [15:0]      mem_write_data_r;

    // The low five command address bits carry the console's address CRC, not location
    assign addr_crc_unused_s = ^bus.cmd_addr[4:0];

    // Next state plus next datapath values; outputs are registered from these
    always_comb begin
        state_next_s  = state_r;
        base_next_s   = base_r;
        oor_next_s    = oor_r;
        idx_next_s    = idx_r;
        hw_buf_next_s = hw_buf_r;
        crc_clear_s   = 1'b0;
        crc_en_s      = 1'b0;
        crc_in_s      = 8'h00;
        last_s        = (idx_r == LAST_IDX);
        case (state_r)
            IDLE: begin
                if (bus.cmd_valid) begin
                    base_next_s  = {bus.cmd_addr[15:5], 5'b00000};
                    oor_next_s   = (bus.cmd_addr >= MEMPAK_ADDR_LIMIT);
                    idx_next_s   = {IDX_W{1'b0}};
                    crc_clear_s  = 1'b1;
                    state_next_s = bus.cmd_write ? WR_HI : RD_REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD_REQ: begin
                state_next_s = RD_WAIT;
            end
            RD_WAIT: begin
                hw_buf_next_s = oor_r ? 16'h0000 : bus.mem_read_data;
                state_next_s  = RD_HI;
            end
            RD_HI: begin
                if (bus.rd_byte_ready) begin
                    crc_en_s     = 1'b1;
                    crc_in_s     = hw_buf_r[15:8];
                    state_next_s = RD_LO;
                end else begin
                    state_next_s = RD_HI;
                end
            end
            RD_LO: begin
                if (bus.rd_byte_ready) begin
                    crc_en_s = 1'b1;
                    crc_in_s = hw_buf_r[7:0];
                    if (last_s) begin
                        state_next_s = CRC_FIN;
                    end else begin
                        idx_next_s   = idx_r + IDX_W'(1'b1);
                        state_next_s = RD_REQ;
                    end
                end else begin
                    state_next_s = RD_LO;
                end
            end
            WR_HI: begin
                if (bus.wr_byte_valid) begin
                    crc_en_s      = 1'b1;
                    crc_in_s      = bus.wr_byte;
                    hw_buf_next_s = {bus.wr_byte, hw_buf_r[7:0]};
                    state_next_s  = WR_LO;
                end else begin
                    state_next_s = WR_HI;
                end
            end
            WR_LO: begin
                if (bus.wr_byte_valid) begin
                    crc_en_s      = 1'b1;
                    crc_in_s      = bus.wr_byte;
                    hw_buf_next_s = {hw_buf_r[15:8], bus.wr_byte};
                    state_next_s  = WR_COMMIT;
                end else begin
                    state_next_s = WR_LO;
                end
            end
            WR_COMMIT: begin
                if (last_s) begin
                    state_next_s = CRC_FIN;
                end else begin
                    idx_next_s   = idx_r + IDX_W'(1'b1);
                    state_next_s = WR_HI;
                end
            end
            CRC_FIN: begin
                state_next_s = DONE;
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        addr_next_s = base_next_s + 16'({idx_next_s, 1'b0});
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Transfer context: block base, range flag, halfword index and staging buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_r   <= 16'h0000;
            oor_r    <= 1'b0;
            idx_r    <= {IDX_W{1'b0}};
            hw_buf_r <= 16'h0000;
        end else begin
            base_r   <= base_next_s;
            oor_r    <= oor_next_s;
            idx_r    <= idx_next_s;
            hw_buf_r <= hw_buf_next_s;
        end
    end

    mempak_crc8 u_crc (
        .clk     (clk),
        .reset   (reset),
        .clear   (crc_clear_s),
        .byte_en (crc_en_s),
        .byte_in (crc_in_s),
        .crc_out (crc_run_s)
    );

    // Output stage decoded one cycle ahead from the next state, so every port is a flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_ready_r        <= 1'b1;
            busy_r             <= 1'b0;
            wr_byte_ready_r    <= 1'b0;
            rd_byte_valid_r    <= 1'b0;
            rd_byte_r          <= 8'h00;
            crc_valid_r        <= 1'b0;
            crc_out_r          <= 8'h00;
            mem_read_enable_r  <= 1'b0;
            mem_write_enable_r <= 1'b0;
            mem_address_r      <= 16'h0000;
            mem_write_data_r   <= 16'h0000;
        end else begin
            cmd_ready_r        <= (state_next_s == IDLE);
            busy_r             <= (state_next_s != IDLE);
            wr_byte_ready_r    <= (state_next_s == WR_HI) || (state_next_s == WR_LO);
            rd_byte_valid_r    <= (state_next_s == RD_HI) || (state_next_s == RD_LO);
            crc_valid_r        <= (state_next_s == DONE);
            mem_read_enable_r  <= (state_next_s == RD_REQ) && !oor_next_s;
            mem_write_enable_r <= (state_next_s == WR_COMMIT) && !oor_next_s;
            mem_address_r      <= ((state_next_s == RD_REQ) || (state_next_s == WR_COMMIT)) ?
                                  addr_next_s : 16'h0000;
            mem_write_data_r   <= (state_next_s == WR_COMMIT) ? hw_buf_next_s : 16'h0000;
            case (state_next_s)
                RD_HI:   rd_byte_r <= hw_buf_next_s[15:8];
                RD_LO:   rd_byte_r <= hw_buf_next_s[7:0];
                default: rd_byte_r <= 8'h00;
            endcase
            // Augmentation byte applied on the way into the held result
            if (state_r == CRC_FIN) begin
                crc_out_r <= crc8_byte_update(crc_run_s, 8'h00);
            end else begin
                crc_out_r <= crc_out_r;
            end
        end
    end

    assign bus.cmd_ready        = cmd_ready_r;
    assign bus.busy             = busy_r;
    assign bus.wr_byte_ready    = wr_byte_ready_r;
    assign bus.rd_byte_valid    = rd_byte_valid_r;
    assign bus.rd_byte          = rd_byte_r;
    assign bus.crc_valid        = crc_valid_r;
    assign bus.crc_out          = crc_out_r;
    assign bus.mem_read_enable  = mem_read_enable_r;
    assign bus.mem_write_enable = mem_write_enable_r;
    assign bus.mem_address      = mem_address_r;
    assign bus.mem_write_data   = mem_write_data_r;

endmodule

// File: tb/tb_mempak_block_xfer.sv
// Self-checking bench for mempak_block_xfer: SPRAM stand-in, byte-array reference and bit-serial CRC model.
module tb_mempak_block_xfer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mempak_block_xfer_if bus ();

    mempak_block_xfer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    bit [15:0]   spram   [0:16383];
    bit [7:0]    ref_mem [0:32767];
    int          rd_strobes = 0;
    int          wr_strobes = 0;
    int          bad_strobes = 0;
    logic [15:0] rd_log [$];
    logic [31:0] wr_log [$];

    logic [7:0]  wbytes [0:31];
    logic [7:0]  got [$];
    logic [7:0]  got_crc;
    int          crc_pulses;
    int          first_lat;
    int          hold_err;
    int          proto_err;
    logic [7:0]  write_crc;

    // SPRAM stand-in: read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (bus.mem_read_enable === 1'b1 && bus.mem_write_enable === 1'b1) bad_strobes++;
        if ((bus.mem_read_enable === 1'b1 || bus.mem_write_enable === 1'b1) &&
            (bus.mem_address[15] !== 1'b0 || bus.mem_address[0] !== 1'b0)) bad_strobes++;
        if (bus.mem_write_enable === 1'b1) begin
            spram[bus.mem_address[14:1]] <= bus.mem_write_data;
            wr_strobes++;
            wr_log.push_back({bus.mem_address, bus.mem_write_data});
        end
        if (bus.mem_read_enable === 1'b1) begin
            bus.mem_read_data <= spram[bus.mem_address[14:1]];
            rd_strobes++;
            rd_log.push_back(bus.mem_address);
        end else begin
            bus.mem_read_data <= 16'hA5A5;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Message bits followed by eight zero bits, divided by x^8+x^7+x^2+1
    function automatic logic [7:0] ref_crc(input logic [7:0] s [$]);
        int r;
        logic [7:0] m [$];
        r = 0;
        m = s;
        m.push_back(8'h00);
        foreach (m[i]) begin
            for (int b = 7; b >= 0; b--) begin
                r = (r << 1) | int'(m[i][b]);
                if ((r & 32'h100) != 0) r = r ^ 32'h185;
            end
        end
        return r[7:0];
    endfunction

    function automatic logic [7:0] ref_read(input logic [15:0] addr, input int i);
        if (addr[15]) return 8'h00;
        return ref_mem[int'(addr & 16'h7FE0) + i];
    endfunction

    function automatic logic [7:0] exp_read_crc(input logic [15:0] addr);
        logic [7:0] q [$];
        for (int i = 0; i < 32; i++) q.push_back(ref_read(addr, i));
        return ref_crc(q);
    endfunction

    function automatic logic [7:0] exp_write_crc();
        logic [7:0] q [$];
        for (int i = 0; i < 32; i++) q.push_back(wbytes[i]);
        return ref_crc(q);
    endfunction

    function automatic int stream_bad(input logic [15:0] addr);
        int n;
        n = (got.size() == 32) ? 0 : 1;
        for (int i = 0; i < 32 && i < got.size(); i++)
            if (got[i] !== ref_read(addr, i)) n++;
        return n;
    endfunction

    function automatic int wr_bad(input int n0, input logic [15:0] addr, input int nhalf);
        int n;
        logic [31:0] e;
        n = 0;
        for (int i = 0; i < nhalf; i++) begin
            e = {(addr & 16'hFFE0) + 16'(2 * i), wbytes[2 * i], wbytes[2 * i + 1]};
            if (n0 + i >= wr_log.size() || wr_log[n0 + i] !== e) n++;
        end
        return n;
    endfunction

    function automatic int rd_addr_bad(input int r0, input logic [15:0] addr);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++)
            if (r0 + i >= rd_log.size() || rd_log[r0 + i] !== (addr & 16'hFFE0) + 16'(2 * i)) n++;
        return n;
    endfunction

    task automatic commit_ref(input logic [15:0] addr, input int nhalf);
        if (!addr[15])
            for (int i = 0; i < 2 * nhalf; i++) ref_mem[int'(addr & 16'h7FE0) + i] = wbytes[i];
    endtask

    task automatic random_wbytes();
        for (int i = 0; i < 32; i++) wbytes[i] = 8'($urandom);
    endtask

    // One command from accept to return to idle; the driver stands in for decoder and transmitter
    task automatic run_xfer(input bit wr, input logic [15:0] addr, input int gap_pct,
                            input int stall_at, input int stall_len, input int abort_after, input bit noise);
        int cyc;
        int k;
        int stall_cnt;
        bit stalling;
        logic [7:0] held;
        cyc = 0; k = 0; stall_cnt = 0; stalling = 1'b0; held = 8'h00;
        got.delete();
        crc_pulses = 0; first_lat = -1; hold_err = 0; proto_err = 0;
        if (bus.cmd_ready !== 1'b1) proto_err++;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        tick();
        cyc = 1;
        bus.cmd_valid = noise;
        bus.cmd_write = ~wr;
        bus.cmd_addr  = 16'($urandom);
        while (cyc < 2000) begin
            if (bus.cmd_ready === 1'b1) break;
            if (bus.busy !== 1'b1) proto_err++;
            if (stalling && (bus.rd_byte !== held || bus.rd_byte_valid !== 1'b1)) hold_err++;
            stalling = 1'b0;
            if (bus.crc_valid === 1'b1) begin
                crc_pulses++;
                got_crc = bus.crc_out;
                bus.cmd_valid = 1'b0;
            end
            if (bus.rd_byte_valid === 1'b1) begin
                if (first_lat < 0) first_lat = cyc;
                if (got.size() == stall_at && stall_cnt < stall_len) begin
                    bus.rd_byte_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    bus.rd_byte_ready = ($urandom_range(99) >= gap_pct);
                end
                if (bus.rd_byte_ready) begin
                    got.push_back(bus.rd_byte);
                end else begin
                    stalling = 1'b1;
                    held = bus.rd_byte;
                end
            end else begin
                bus.rd_byte_ready = 1'($urandom_range(1));
            end
            if (bus.wr_byte_ready === 1'b1) begin
                bus.wr_byte_valid = (k < 32) && ($urandom_range(99) >= gap_pct);
                bus.wr_byte = (k < 32) ? wbytes[k] : 8'h00;
                if (bus.wr_byte_valid) k++;
            end else begin
                bus.wr_byte_valid = 1'($urandom_range(1));
                bus.wr_byte = 8'($urandom);
            end
            tick();
            cyc++;
            if (abort_after > 0 && k == abort_after) return;
        end
        if (cyc >= 2000) begin
            checks++; errors++;
            $display("FAIL xfer_timeout addr=%h cycles=%0d required<2000", addr, cyc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 16'h0000;
        bus.wr_byte_valid = 1'b0; bus.wr_byte = 8'h00; bus.rd_byte_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if ({bus.rd_byte_valid, bus.wr_byte_ready, bus.crc_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_handshakes got=%b exp=000", {bus.rd_byte_valid, bus.wr_byte_ready, bus.crc_valid}); end
        checks++; if (bus.crc_out !== 8'h00) begin errors++; $display("FAIL reset_crc_out got=%h exp=00", bus.crc_out); end
        checks++; if ({bus.mem_read_enable, bus.mem_write_enable, bus.mem_address} !== 18'h0) begin
            errors++; $display("FAIL reset_mem_port got=%b/%b/%h exp=0/0/0000",
                               bus.mem_read_enable, bus.mem_write_enable, bus.mem_address); end
    endtask

    task automatic test_write_seq();
        int n0;
        for (int i = 0; i < 32; i++) wbytes[i] = 8'(i);
        n0 = wr_log.size();
        run_xfer(1'b1, 16'h0020, 0, -1, 0, 0, 1'b0);
        checks++; if (wr_log.size() - n0 != 16) begin errors++; $display("FAIL wseq_count got=%0d exp=16", wr_log.size() - n0); end
        checks++; if (wr_bad(n0, 16'h0020, 16) != 0) begin errors++; $display("FAIL wseq_data bad=%0d exp=0 first=%h", wr_bad(n0, 16'h0020, 16), wr_log[n0]); end
        checks++; if (crc_pulses != 1) begin errors++; $display("FAIL wseq_crc_pulses got=%0d exp=1", crc_pulses); end
        checks++; if (got_crc !== exp_write_crc()) begin errors++; $display("FAIL wseq_crc got=%h exp=%h", got_crc, exp_write_crc()); end
        checks++; if (proto_err != 0) begin errors++; $display("FAIL wseq_busy_ready got=%0d exp=0", proto_err); end
        write_crc = exp_write_crc();
        commit_ref(16'h0020, 16);
    endtask

    task automatic test_read_back();
        int r0;
        r0 = rd_log.size();
        run_xfer(1'b0, 16'h0035, 0, -1, 0, 0, 1'b0);
        checks++; if (stream_bad(16'h0035) != 0) begin errors++; $display("FAIL rback_stream bad=%0d exp=0 size=%0d", stream_bad(16'h0035), got.size()); end
        checks++; if (first_lat != 3) begin errors++; $display("FAIL rback_latency got=%0d exp=3", first_lat); end
        checks++; if (rd_log.size() - r0 != 16) begin errors++; $display("FAIL rback_strobes got=%0d exp=16", rd_log.size() - r0); end
        checks++; if (rd_addr_bad(r0, 16'h0035) != 0) begin errors++; $display("FAIL rback_addr bad=%0d exp=0", rd_addr_bad(r0, 16'h0035)); end
        checks++; if (got_crc !== write_crc) begin errors++; $display("FAIL rback_crc got=%h exp=%h", got_crc, write_crc); end
        checks++; if (crc_pulses != 1) begin errors++; $display("FAIL rback_crc_pulses got=%0d exp=1", crc_pulses); end
    endtask

    task automatic test_zero_block();
        run_xfer(1'b0, 16'h0100, 20, -1, 0, 0, 1'b0);
        checks++; if (stream_bad(16'h0100) != 0) begin errors++; $display("FAIL zero_stream bad=%0d exp=0", stream_bad(16'h0100)); end
        checks++; if (got_crc !== 8'h00) begin errors++; $display("FAIL zero_crc got=%h exp=00", got_crc); end
    endtask

    task automatic test_out_of_range();
        int rs;
        int ws;
        rs = rd_strobes; ws = wr_strobes;
        run_xfer(1'b0, 16'h8000, 0, -1, 0, 0, 1'b0);
        checks++; if (rd_strobes - rs != 0 || wr_strobes - ws != 0) begin
            errors++; $display("FAIL oor_read_strobes got=%0d/%0d exp=0/0", rd_strobes - rs, wr_strobes - ws); end
        checks++; if (stream_bad(16'h8000) != 0) begin errors++; $display("FAIL oor_read_stream bad=%0d exp=0", stream_bad(16'h8000)); end
        checks++; if (got_crc !== 8'h00) begin errors++; $display("FAIL oor_read_crc got=%h exp=00", got_crc); end
        checks++; if (first_lat != 3) begin errors++; $display("FAIL oor_latency got=%0d exp=3", first_lat); end
        random_wbytes();
        ws = wr_strobes;
        run_xfer(1'b1, 16'hC000, 30, -1, 0, 0, 1'b0);
        checks++; if (wr_strobes - ws != 0) begin errors++; $display("FAIL oor_write_strobes got=%0d exp=0", wr_strobes - ws); end
        checks++; if (got_crc !== exp_write_crc()) begin errors++; $display("FAIL oor_write_crc got=%h exp=%h", got_crc, exp_write_crc()); end
    endtask

    task automatic test_backpressure();
        int n0;
        int r0;
        random_wbytes();
        n0 = wr_log.size();
        run_xfer(1'b1, 16'h1240, 40, -1, 0, 0, 1'b0);
        checks++; if (wr_bad(n0, 16'h1240, 16) != 0 || wr_log.size() - n0 != 16) begin
            errors++; $display("FAIL bp_write_data bad=%0d count=%0d exp=0/16", wr_bad(n0, 16'h1240, 16), wr_log.size() - n0); end
        checks++; if (got_crc !== exp_write_crc()) begin errors++; $display("FAIL bp_write_crc got=%h exp=%h", got_crc, exp_write_crc()); end
        commit_ref(16'h1240, 16);
        r0 = rd_log.size();
        run_xfer(1'b0, 16'h1240, 0, 7, 5, 0, 1'b0);
        checks++; if (hold_err != 0) begin errors++; $display("FAIL bp_hold got=%0d exp=0", hold_err); end
        checks++; if (rd_log.size() - r0 != 16) begin errors++; $display("FAIL bp_rd_strobes got=%0d exp=16", rd_log.size() - r0); end
        checks++; if (stream_bad(16'h1240) != 0) begin errors++; $display("FAIL bp_stream bad=%0d exp=0", stream_bad(16'h1240)); end
        checks++; if (got_crc !== exp_read_crc(16'h1240)) begin errors++; $display("FAIL bp_crc got=%h exp=%h", got_crc, exp_read_crc(16'h1240)); end
        run_xfer(1'b0, 16'h1240, 50, -1, 0, 0, 1'b1);
        checks++; if (hold_err != 0 || proto_err != 0) begin errors++; $display("FAIL busy_ignore hold=%0d proto=%0d exp=0/0", hold_err, proto_err); end
        checks++; if (stream_bad(16'h1240) != 0) begin errors++; $display("FAIL busy_stream bad=%0d exp=0", stream_bad(16'h1240)); end
    endtask

    task automatic test_reset_mid_write();
        int n0;
        random_wbytes();
        n0 = wr_log.size();
        run_xfer(1'b1, 16'h0400, 0, -1, 0, 11, 1'b0);
        reset = 1'b1;
        bus.wr_byte_valid = 1'b0;
        #1;
        checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.wr_byte_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ctrl got=%b%b%b exp=100", bus.cmd_ready, bus.busy, bus.wr_byte_ready); end
        checks++; if (bus.crc_out !== 8'h00 || bus.mem_write_enable !== 1'b0) begin
            errors++; $display("FAIL rst_mid_out crc=%h we=%b exp=00/0", bus.crc_out, bus.mem_write_enable); end
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (wr_log.size() - n0 != 5) begin errors++; $display("FAIL rst_mid_writes got=%0d exp=5", wr_log.size() - n0); end
        checks++; if (wr_bad(n0, 16'h0400, 5) != 0) begin errors++; $display("FAIL rst_mid_data bad=%0d exp=0", wr_bad(n0, 16'h0400, 5)); end
        commit_ref(16'h0400, 5);
        run_xfer(1'b0, 16'h0400, 10, -1, 0, 0, 1'b0);
        checks++; if (stream_bad(16'h0400) != 0) begin errors++; $display("FAIL rst_after_stream bad=%0d exp=0", stream_bad(16'h0400)); end
        checks++; if (got_crc !== exp_read_crc(16'h0400) || crc_pulses != 1) begin
            errors++; $display("FAIL rst_after_crc got=%h exp=%h pulses=%0d", got_crc, exp_read_crc(16'h0400), crc_pulses); end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [7:0]  wc;
        for (int t = 0; t < 4; t++) begin
            a = 16'($urandom_range(0, 32767));
            random_wbytes();
            run_xfer(1'b1, a, 25, -1, 0, 0, 1'b0);
            wc = exp_write_crc();
            checks++; if (got_crc !== wc) begin errors++; $display("FAIL rand_wcrc t=%0d got=%h exp=%h", t, got_crc, wc); end
            commit_ref(a, 16);
            run_xfer(1'b0, 16'(a ^ 16'h001F), 35, $urandom_range(31), $urandom_range(1, 6), 0, 1'b1);
            checks++; if (stream_bad(a) != 0 || hold_err != 0) begin
                errors++; $display("FAIL rand_stream t=%0d bad=%0d hold=%0d exp=0/0", t, stream_bad(a), hold_err); end
            checks++; if (got_crc !== wc) begin errors++; $display("FAIL rand_rcrc t=%0d got=%h exp=%h", t, got_crc, wc); end
        end
    endtask

    task automatic test_bus_rules();
        checks++; if (bad_strobes != 0) begin errors++; $display("FAIL bus_rules got=%0d exp=0", bad_strobes); end
    endtask

    initial begin
        test_reset();
        test_write_seq();
        test_read_back();
        test_zero_block();
        test_out_of_range();
        test_backpressure();
        test_reset_mid_write();
        test_random();
        test_bus_rules();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
